// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - four-VC burst arbiter draining FWFT VC FIFOs into one shared output FIFO
// Round-robin with bounded bursts; almost-full pauses arbitration without losing grant or burst position.
module vc_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int BURST_MAX  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              vc_enable,
  input  logic [3:0]              fifo_empty,
  input  logic [4*DATA_WIDTH-1:0] fifo_data,
  input  logic                    out_almost_full,
  input  logic                    out_almost_empty,
  input  logic                    out_full,
  output logic [3:0]              pop,
  output logic                    push_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [1:0]              grant_vc,
  output logic                    pause,
  output logic                    error
);

  typedef enum logic [1:0] {IDLE, GRANT, PAUSE} state_t;

  state_t                state_q;
  logic [1:0]            grant_q;
  logic [2:0]            burst_q;
  logic                  push_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  error_q;

  logic [3:0]            eligible;
  logic                  grant_ok;
  logic                  pop_en;
  logic [DATA_WIDTH-1:0] pop_word;
  logic [2:0]            rot_sel;
  logic [2:0]            any_sel;
  logic [3:0]            burst_inc;

  // Returns {found, vc}: first eligible VC at offsets 1..span from 'from', modulo 4.
  function automatic logic [2:0] next_elig(input logic [1:0] from, input logic [3:0] elig,
                                           input int span);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (k <= span && !res[2] && elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    eligible  = vc_enable & ~fifo_empty;
    grant_ok  = eligible[grant_q];
    pop_en    = !reset && (state_q == GRANT) && grant_ok && !out_almost_full && !out_full;
    pop       = pop_en ? (4'b0001 << grant_q) : 4'b0000;
    pop_word  = fifo_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    rot_sel   = next_elig(grant_q, eligible, 3);
    any_sel   = next_elig(grant_q, eligible, 4);
    burst_inc = {1'b0, burst_q} + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      burst_q <= 3'd0;
      push_q  <= 1'b0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      push_q <= pop_en;
      if (pop_en) data_q <= pop_word;
      if (push_q && out_full) error_q <= 1'b1;

      // Almost-full wins over everything; grant and burst position freeze until resume.
      if (out_almost_full) begin
        state_q <= PAUSE;
      end else begin
        case (state_q)
          PAUSE: if (out_almost_empty) state_q <= IDLE;
          IDLE: begin
            if (|eligible) begin
              state_q <= GRANT;
              if (!grant_ok) begin
                grant_q <= any_sel[1:0];
                burst_q <= 3'd0;
              end
            end
          end
          GRANT: begin
            if (!(|eligible)) begin
              state_q <= IDLE;
            end else if (pop_en) begin
              if (burst_inc < 4'(BURST_MAX)) begin
                burst_q <= burst_inc[2:0];
              end else begin
                burst_q <= 3'd0;
                if (rot_sel[2]) grant_q <= rot_sel[1:0];
              end
            end else if (!grant_ok) begin
              grant_q <= any_sel[1:0];
              burst_q <= 3'd0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign push_out = push_q;
  assign data_out = data_q;
  assign grant_vc = grant_q;
  assign pause    = (state_q == PAUSE);
  assign error    = error_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// tb/tb_vc_arbiter.sv - scoreboard bench for vc_arbiter with behavioural FWFT VC FIFOs
// Stimulus pushes expected output words; a negedge monitor pops and compares on each push_out.
module tb_vc_arbiter;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    vc_enable;
  logic [3:0]    fifo_empty;
  logic [4*DW-1:0] fifo_data;
  logic          out_almost_full, out_almost_empty, out_full;
  logic [3:0]    pop;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic [1:0]    grant_vc;
  logic          pause, error;

  vc_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset), .vc_enable(vc_enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .out_almost_full(out_almost_full),
    .out_almost_empty(out_almost_empty), .out_full(out_full), .pop(pop),
    .push_out(push_out), .data_out(data_out), .grant_vc(grant_vc), .pause(pause),
    .error(error)
  );

  always #5 clk = ~clk;

  int            rd[4] = '{default: 0};
  int            wr[4] = '{default: 0};
  logic [DW-1:0] mem[4][16];
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            mon_en = 0;
  bit            have_prev = 0;
  logic [3:0]    prev_pop;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]          = (rd[i] == wr[i]);
      fifo_data[i*DW +: DW]  = mem[i][rd[i] & 15];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (pop[i]) rd[i] <= rd[i] + 1;
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] d;
    if (mon_en) begin
      if (have_prev) check("push_follows_pop", int'(push_out), int'(|prev_pop));
      check("pop_onehot0", int'($onehot0(pop)), 1);
      if (push_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_push", int'(data_out), -1);
        end else begin
          d = exp_q.pop_front();
          check("data_out", int'(data_out), int'(d));
        end
      end
      prev_pop  = pop;
      have_prev = 1;
    end
  end

  task automatic load(input int vc, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      mem[vc][wr[vc] & 15] = DW'(base + k);
      wr[vc]++;
    end
  endtask

  task automatic expect_word(input int d);
    exp_q.push_back(DW'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) wr[i] = rd[i];
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int t = 0; t < bound && exp_q.size() != 0; t++) tick();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic burst_run(input string name, input int len);
    int t;
    t = 0;
    while (!push_out && t < 20) begin
      tick();
      t++;
    end
    for (int k = 0; k < len; k++) begin
      check(name, int'(push_out), 1);
      tick();
    end
    check({name, "_end"}, int'(push_out), 0);
  endtask

  task automatic wait_vc_pops(input logic [3:0] onehot, input int want);
    int cnt;
    cnt = 0;
    for (int t = 0; t < 40 && cnt < want; t++) begin
      tick();
      if (pop == onehot) cnt++;
    end
    check("vc_pop_count", cnt, want);
  endtask

  initial begin
    reset = 1'b1;
    vc_enable = 4'hF;
    out_almost_full = 1'b0;
    out_almost_empty = 1'b0;
    out_full = 1'b0;

    // Reset and idle with every VC empty
    do_reset();
    mon_en = 1;
    check("rst_data_out", int'(data_out), 0);
    check("rst_error", int'(error), 0);
    for (int c = 0; c < 10; c++) begin
      check("idle_pop", int'(pop), 0);
      check("idle_push", int'(push_out), 0);
      check("idle_grant", int'(grant_vc), 0);
      check("idle_pause", int'(pause), 0);
      tick();
    end

    // Only VC2 holds 6 words: the burst limit finds no other VC, so 6 back-to-back pops
    load(2, 6, 32);
    for (int k = 0; k < 6; k++) expect_word(32 + k);
    burst_run("vc2_b2b_push", 6);
    wait_drain("vc2_drain", 20);

    // All VCs full: 4-word bursts rotating VC0..VC3 with no idle cycle
    do_reset();
    for (int v = 0; v < 4; v++) load(v, 8, v * 16);
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 4; v++)
        for (int k = 0; k < 4; k++) expect_word(v * 16 + r * 4 + k);
    burst_run("rr_b2b_push", 32);
    wait_drain("rr_drain", 20);

    // Pause after VC1's 2nd pop; resume must finish VC1's burst with 2 more words
    do_reset();
    load(1, 6, 16);
    load(2, 2, 32);
    foreach (exp_q[i]) ;
    expect_word(16); expect_word(17); expect_word(18); expect_word(19);
    expect_word(32); expect_word(33); expect_word(20); expect_word(21);
    wait_vc_pops(4'b0010, 2);
    tick();
    out_almost_full = 1'b1;
    #1;
    check("af_pop_blocked", int'(pop), 0);
    tick();
    check("af_pause", int'(pause), 1);
    check("af_grant_kept", int'(grant_vc), 1);
    for (int c = 0; c < 3; c++) begin
      check("pause_no_pop", int'(pop), 0);
      check("pause_held", int'(pause), 1);
      tick();
    end
    out_almost_full = 1'b0;
    out_almost_empty = 1'b1;
    tick();
    check("resume_pause_low", int'(pause), 0);
    out_almost_empty = 1'b0;
    wait_drain("pause_drain", 40);
    check("pause_no_error", int'(error), 0);

    // out_full during a push sets a sticky error
    do_reset();
    load(0, 2, 8);
    expect_word(8); expect_word(9);
    for (int t = 0; t < 20 && pop == 4'b0000; t++) tick();
    check("full_first_pop", int'(pop), 1);
    tick();
    check("full_err_before", int'(error), 0);
    out_full = 1'b1;
    tick();
    check("full_error_set", int'(error), 1);
    check("full_no_push", int'(push_out), 0);
    out_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("error_sticky", int'(error), 1);
    end
    wait_drain("full_drain", 20);
    do_reset();
    check("error_cleared", int'(error), 0);

    // Reset mid-burst on VC3: pending pop dropped, arbitration restarts at VC0
    load(3, 8, 48);
    expect_word(48); expect_word(49);
    wait_vc_pops(4'b1000, 2);
    tick();
    reset = 1'b1;
    #1;
    check("rst_pop_suppressed", int'(pop), 0);
    tick();
    check("rst_mid_grant", int'(grant_vc), 0);
    check("rst_mid_push", int'(push_out), 0);
    check("rst_mid_pause", int'(pause), 0);
    load(0, 2, 0);
    load(1, 5, 16);
    reset = 1'b0;
    expect_word(0); expect_word(1);
    for (int k = 0; k < 4; k++) expect_word(16 + k);
    for (int k = 0; k < 4; k++) expect_word(50 + k);
    expect_word(20); expect_word(54); expect_word(55);
    wait_drain("rst_restart_drain", 60);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
